// File: rtl/fir_coeff_stream_mac_if.sv
// ============================================================================
// Module   : fir_coeff_stream_mac_if
// Purpose  : Coefficient stream, sample stream and result bundle of the FIR MAC.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fir_coeff_stream_mac_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32
);
  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_last;
  logic                     coef_err;
  logic                     bank_sel;
  logic                     sample_valid;
  logic                     sample_ready;
  logic signed [DATA_W-1:0] sample_in;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;

  modport master (
    output coef_valid, coef_data, coef_last, sample_valid, sample_in,
    input  coef_ready, coef_err, bank_sel, sample_ready, out_valid, out_data
  );

  modport slave (
    input  coef_valid, coef_data, coef_last, sample_valid, sample_in,
    output coef_ready, coef_err, bank_sel, sample_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/fir_coeff_stream_mac.sv
// ============================================================================
// Module   : fir_coeff_stream_mac
// Purpose  : Time-multiplexed FIR, one MAC per clock, double-buffered coefficients.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fir_coeff_stream_mac #(
  parameter int NUM_TAPS  = 101,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15,
  parameter int OUT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_coeff_stream_mac_if.slave bus
);

  localparam int c_TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int c_PROD_W = DATA_W + COEF_W;
  localparam logic [c_TAP_W-1:0] c_LAST_TAP = c_TAP_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [DATA_W-1:0] r_x    [NUM_TAPS];
  logic signed [COEF_W-1:0] r_bank [2][NUM_TAPS];
  logic                     r_bank_sel;
  logic                     r_commit_pending;
  logic                     r_coef_err;
  logic                     r_out_valid;
  logic [c_TAP_W-1:0]       r_wr_idx;
  logic [c_TAP_W-1:0]       r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [OUT_W-1:0]  r_out_data;

  logic                       w_coef_fire;
  logic                       w_wr_at_end;
  logic                       w_coef_bad;
  logic                       w_coef_commit;
  logic                       w_commit;
  logic                       w_sample_ready;
  logic                       w_sample_fire;
  logic signed [COEF_W-1:0]   w_coef_act;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_shifted;
  logic signed [OUT_W-1:0]    w_sat;

  // A load is malformed when coef_last does not coincide with the final slot.
  assign w_coef_fire    = bus.coef_valid & ~r_commit_pending;
  assign w_wr_at_end    = (r_wr_idx == c_LAST_TAP);
  assign w_coef_bad     = w_coef_fire & (bus.coef_last ^ w_wr_at_end);
  assign w_coef_commit  = w_coef_fire & bus.coef_last & w_wr_at_end;
  assign w_commit       = (r_state == S_IDLE) & r_commit_pending;
  assign w_sample_ready = (r_state == S_IDLE) & ~r_commit_pending;
  assign w_sample_fire  = bus.sample_valid & w_sample_ready;

  assign w_coef_act = r_bank[r_bank_sel][r_tap];
  assign w_prod     = r_x[r_tap] * w_coef_act;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_shifted  = r_acc >>> OUT_SHIFT;

  // Clamp when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    w_sat = w_shifted[OUT_W-1:0];
    if (!((&w_shifted[ACC_W-1:OUT_W-1]) || (~|w_shifted[ACC_W-1:OUT_W-1]))) begin
      w_sat = w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_sample_fire) w_state_next = S_MAC;
      S_MAC:   if (r_tap == c_LAST_TAP) w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_bank_sel       <= 1'b0;
      r_commit_pending <= 1'b0;
      r_coef_err       <= 1'b0;
      r_out_valid      <= 1'b0;
      r_wr_idx         <= '0;
      r_tap            <= '0;
      r_acc            <= '0;
      r_out_data       <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_x[k]       <= '0;
        r_bank[0][k] <= '0;
        r_bank[1][k] <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_coef_err  <= w_coef_bad;
      r_out_valid <= (r_state == S_OUT);

      // The shadow bank is whichever one the MAC is not reading.
      if (w_coef_fire) begin
        if (w_coef_bad) begin
          r_wr_idx <= '0;
        end else begin
          r_bank[~r_bank_sel][r_wr_idx] <= bus.coef_data;
          if (w_coef_commit) begin
            r_wr_idx         <= '0;
            r_commit_pending <= 1'b1;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
      end

      if (w_commit) begin
        r_bank_sel       <= ~r_bank_sel;
        r_commit_pending <= 1'b0;
      end

      if (w_sample_fire) begin
        r_x[0] <= bus.sample_in;
        for (int k = NUM_TAPS - 1; k > 0; k--) begin
          r_x[k] <= r_x[k-1];
        end
        r_acc <= '0;
        r_tap <= '0;
      end

      if (r_state == S_MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_tap <= (r_tap == c_LAST_TAP) ? '0 : r_tap + 1'b1;
      end

      if (r_state == S_OUT) begin
        r_out_data <= w_sat;
      end
    end
  end

  assign bus.coef_ready   = ~r_commit_pending;
  assign bus.coef_err     = r_coef_err;
  assign bus.bank_sel     = r_bank_sel;
  assign bus.sample_ready = w_sample_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_stream_mac.sv
// ============================================================================
// Module   : tb_fir_coeff_stream_mac
// Purpose  : Directed bench: 4-tap Q15 instance plus a 4-tap saturating instance.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_coeff_stream_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_coeff_stream_mac_if #(.DATA_W(16), .COEF_W(16), .OUT_W(32)) fb ();
  fir_coeff_stream_mac_if #(.DATA_W(16), .COEF_W(16), .OUT_W(16)) sb ();

  fir_coeff_stream_mac #(
    .NUM_TAPS(4), .DATA_W(16), .COEF_W(16), .ACC_W(40), .OUT_SHIFT(15), .OUT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(fb)
  );

  fir_coeff_stream_mac #(
    .NUM_TAPS(4), .DATA_W(16), .COEF_W(16), .ACC_W(40), .OUT_SHIFT(0), .OUT_W(16)
  ) dut_sat (
    .clk(clk), .rst(rst), .bus(sb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_coef(input logic signed [15:0] d, input logic last);
    int n = 0;
    fb.coef_valid = 1'b1;
    fb.coef_data  = d;
    fb.coef_last  = last;
    while (!fb.coef_ready && n < 50) begin step(); n++; end
    check("coef_ready", longint'(fb.coef_ready), 1);
    step();
    fb.coef_valid = 1'b0;
    fb.coef_last  = 1'b0;
  endtask

  task automatic send_sample(input logic signed [15:0] d, output int acc_cyc);
    int n = 0;
    fb.sample_valid = 1'b1;
    fb.sample_in    = d;
    while (!fb.sample_ready && n < 50) begin step(); n++; end
    check("sample_ready", longint'(fb.sample_ready), 1);
    step();
    acc_cyc = cyc;
    fb.sample_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!fb.out_valid && n < 40) begin step(); n++; end
    check(tag, longint'(fb.out_valid), 1);
  endtask

  task automatic sat_coef(input logic signed [15:0] d, input logic last);
    sb.coef_valid = 1'b1;
    sb.coef_data  = d;
    sb.coef_last  = last;
    check("sat_coef_ready", longint'(sb.coef_ready), 1);
    step();
    sb.coef_valid = 1'b0;
    sb.coef_last  = 1'b0;
  endtask

  task automatic sat_sample(input logic signed [15:0] d, input string tag, input longint exp);
    int n = 0;
    sb.sample_valid = 1'b1;
    sb.sample_in    = d;
    while (!sb.sample_ready && n < 50) begin step(); n++; end
    step();
    sb.sample_valid = 1'b0;
    n = 0;
    while (!sb.out_valid && n < 40) begin step(); n++; end
    check({tag, "_valid"}, longint'(sb.out_valid), 1);
    check(tag, longint'(sb.out_data), exp);
  endtask

  initial begin
    int acc;
    int pulses;
    logic signed [15:0] h1 [4];
    logic signed [15:0] s1 [4];
    longint e1 [4];

    h1 = '{16384, 8192, -8192, 32767};
    s1 = '{32767, 0, 0, 0};
    e1 = '{16383, 8191, -8192, 32766};

    fb.coef_valid = 0; fb.coef_data = 0; fb.coef_last = 0;
    fb.sample_valid = 0; fb.sample_in = 0;
    sb.coef_valid = 0; sb.coef_data = 0; sb.coef_last = 0;
    sb.sample_valid = 0; sb.sample_in = 0;

    // Reset and idle state
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_out_data", longint'(fb.out_data), 0);
    check("rst_out_valid", longint'(fb.out_valid), 0);
    check("rst_bank_sel", longint'(fb.bank_sel), 0);
    check("rst_coef_ready", longint'(fb.coef_ready), 1);
    check("rst_sample_ready", longint'(fb.sample_ready), 1);
    check("rst_coef_err", longint'(fb.coef_err), 0);

    // Zero coefficients: output 0 after NUM_TAPS+1 cycles
    send_sample(16'sd1000, acc);
    wait_out("zero_valid");
    check("zero_latency", longint'(cyc - acc), 5);
    check("zero_out", longint'(fb.out_data), 0);
    step();
    check("zero_pulse_width", longint'(fb.out_valid), 0);

    // Impulse response from a clean delay line
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < 4; i++) send_coef(h1[i], i == 3);
    check("commit_cycle_sample_ready", longint'(fb.sample_ready), 0);
    check("commit_cycle_bank_sel", longint'(fb.bank_sel), 0);
    step();
    check("commit_bank_sel", longint'(fb.bank_sel), 1);
    for (int i = 0; i < 4; i++) begin
      send_sample(s1[i], acc);
      wait_out($sformatf("imp_valid%0d", i));
      check($sformatf("imp_out%0d", i), longint'(fb.out_data), e1[i]);
    end

    // Malformed load: last on the second word
    send_coef(16'sd100, 1'b0);
    send_coef(16'sd200, 1'b1);
    check("bad_coef_err", longint'(fb.coef_err), 1);
    step();
    check("bad_coef_err_pulse", longint'(fb.coef_err), 0);
    check("bad_bank_sel", longint'(fb.bank_sel), 1);
    check("bad_no_pending", longint'(fb.coef_ready), 1);
    send_coef(16'sd32767, 1'b0);
    send_coef(16'sd0, 1'b0);
    send_coef(16'sd0, 1'b0);
    send_coef(16'sd0, 1'b1);
    step();
    check("reload_bank_sel", longint'(fb.bank_sel), 0);

    // Commit requested mid-MAC; in-flight sum keeps the old bank
    send_sample(16'sd20000, acc);
    send_coef(16'sd0, 1'b0);
    send_coef(16'sd16384, 1'b0);
    send_coef(16'sd0, 1'b0);
    send_coef(16'sd0, 1'b1);
    fb.sample_valid = 1'b1;
    fb.sample_in    = 16'sd1000;
    wait_out("mid_valid");
    check("mid_out_old_bank", longint'(fb.out_data), 19999);
    check("mid_commit_sample_ready", longint'(fb.sample_ready), 0);
    check("mid_bank_sel_before", longint'(fb.bank_sel), 0);
    step();
    check("mid_bank_sel_after", longint'(fb.bank_sel), 1);
    check("mid_sample_ready_after", longint'(fb.sample_ready), 1);
    check("mid_out_hold", longint'(fb.out_data), 19999);
    step();
    acc = cyc;
    fb.sample_valid = 1'b0;
    wait_out("mid_new_valid");
    check("mid_new_latency", longint'(cyc - acc), 5);
    check("mid_out_new_bank", longint'(fb.out_data), 10000);

    // Reset while at tap 2 aborts the sum
    send_sample(16'sd700, acc);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (fb.out_valid) pulses++;
      step();
    end
    check("abort_no_out_valid", longint'(pulses), 0);
    check("abort_out_data", longint'(fb.out_data), 0);
    check("abort_bank_sel", longint'(fb.bank_sel), 0);
    for (int i = 0; i < 4; i++) send_coef(16'sd32767, i == 3);
    step();
    send_sample(16'sd500, acc);
    wait_out("abort_next_valid");
    check("abort_next_out", longint'(fb.out_data), 499);

    // Saturation instance: OUT_SHIFT=0, OUT_W=16
    for (int i = 0; i < 4; i++) sat_coef(16'sd32767, i == 3);
    step();
    for (int i = 0; i < 4; i++) sat_sample(16'sd32767, $sformatf("sat_pos%0d", i), 32767);
    for (int i = 0; i < 4; i++) sat_coef(-16'sd32768, i == 3);
    step();
    sat_sample(16'sd32767, "sat_neg", -32768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
